// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 set-2 protocol constants and scan-code to ASCII lookup
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // US layout; shift upper-cases letters and selects the symbol row on digits
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = shift ? 8'h29 : 8'h30;
      8'h16: a = shift ? 8'h21 : 8'h31;
      8'h1E: a = shift ? 8'h40 : 8'h32;
      8'h26: a = shift ? 8'h23 : 8'h33;
      8'h25: a = shift ? 8'h24 : 8'h34;
      8'h2E: a = shift ? 8'h25 : 8'h35;
      8'h36: a = shift ? 8'h5E : 8'h36;
      8'h3D: a = shift ? 8'h26 : 8'h37;
      8'h3E: a = shift ? 8'h2A : 8'h38;
      8'h46: a = shift ? 8'h28 : 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      8'h0D: a = 8'h09;
      8'h76: a = 8'h1B;
      default: a = 8'h00;
    endcase
    if (shift && (a >= 8'h61) && (a <= 8'h7A)) begin
      a = a - 8'h20;
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 pin synchroniser, glitch filter and 11-bit frame receiver
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] data_byte,
  output logic       byte_valid
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // index 0 = ps2 clock line, index 1 = ps2 data line
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [CW-1:0] filt_cnt [2];
  logic          clk_prev;
  logic          clk_fall;

  logic [9:0]    shreg;
  logic [10:0]   frame_next;
  logic          frame_ok;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;

  // 2-FF synchroniser then a level filter that needs FILTER_LEN identical samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      filt  <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        filt_cnt[i] <= '0;
      end
      clk_prev <= 1'b1;
    end else begin
      sync1    <= {ps2_data_async, ps2_clk_async};
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i]     <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign clk_fall   = clk_prev & ~filt[0];
  // bits arrive LSB first, so the frame fills from the top: [0]=start .. [10]=stop
  assign frame_next = {filt[1], shreg};
  assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);

  // shift one bit per filtered falling edge; abandon a stalled partial frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      timer      <= '0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clk_fall) begin
        timer <= '0;
        shreg <= frame_next[10:1];
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            data_byte  <= frame_next[8:1];
            byte_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt <= '0;
          timer   <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// rtl/ps2_keyboard_decoder.sv - PS/2 keyboard decoder top; PS2_SHIFT_EN enables shift tracking
module ps2_keyboard_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       key_pressed,
  output logic       key_released
);

  logic [7:0] data_byte;
  logic       byte_valid;
  logic       brk_flag;
  logic       ext_flag;
  logic       shift_held;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2_clk_async  (ps2_clk_async),
    .ps2_data_async (ps2_data_async),
    .data_byte      (data_byte),
    .byte_valid     (byte_valid)
  );

`ifndef PS2_SHIFT_EN
  assign shift_held = 1'b0;
`endif

  // prefix tracking and make/break interpretation of each received byte
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_code    <= '0;
      ascii_code   <= '0;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      brk_flag     <= 1'b0;
      ext_flag     <= 1'b0;
`ifdef PS2_SHIFT_EN
      shift_held   <= 1'b0;
`endif
    end else begin
      key_released <= 1'b0;
      if (byte_valid) begin
        if (data_byte == PS2_EXT) begin
          ext_flag <= 1'b1;
        end else if (data_byte == PS2_BREAK) begin
          brk_flag <= 1'b1;
`ifdef PS2_SHIFT_EN
        end else if ((data_byte == PS2_LSHIFT) || (data_byte == PS2_RSHIFT)) begin
          shift_held <= ~brk_flag;
          brk_flag   <= 1'b0;
          ext_flag   <= 1'b0;
`endif
        end else if (!brk_flag) begin
          scan_code   <= data_byte;
          ascii_code  <= ext_flag ? 8'h00 : scan_to_ascii(data_byte, shift_held);
          key_pressed <= 1'b1;
          ext_flag    <= 1'b0;
        end else begin
          key_released <= 1'b1;
          if (data_byte == scan_code) begin
            key_pressed <= 1'b0;
          end
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// tb/tb_ps2_keyboard_decoder.sv - scoreboard bench for ps2_keyboard_decoder
`timescale 1ns/100ps
module tb_ps2_keyboard_decoder;

  localparam int FLEN = 8;
  localparam int TMO  = 1000;
  localparam int HALF = 12;

  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] SHIFTED [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
    8'h26, 8'h2A, 8'h28};
  localparam logic [7:0] POOL [14] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h29, 8'h5A,
    8'h66, 8'h0D, 8'h76, 8'h12, 8'h59, 8'h07, 8'h1A};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic [7:0] ascii_code;
  logic       key_pressed;
  logic       key_released;

  always #10 clk = ~clk;

  ps2_keyboard_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2_clk_async  (ps2_clk),
    .ps2_data_async (ps2_data),
    .scan_code      (scan_code),
    .ascii_code     (ascii_code),
    .key_pressed    (key_pressed),
    .key_released   (key_released)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] scan;
    logic [7:0] ascii;
    logic       kp;
    logic       kr;
    longint     deadline;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int zero_req = 0, zero_done = 0, end_req = 0, end_done = 0;
  bit mon_en = 1'b0;

  logic [7:0] m_scan = 8'h00, m_ascii = 8'h00;
  logic m_kp = 1'b0, m_brk = 1'b0, m_ext = 1'b0, m_shift = 1'b0;

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic sh);
    for (int i = 0; i < 26; i++) if (c == LETTERS[i]) return (sh ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++) if (c == DIGITS[i]) return sh ? SHIFTED[i] : 8'h30 + 8'(i);
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_exp(input logic [7:0] s, input logic [7:0] a, input logic kp,
                          input logic kr, input longint dl);
    exp_t e;
    e.scan = s; e.ascii = a; e.kp = kp; e.kr = kr; e.deadline = dl;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] a;
    longint dl;
    dl = cyc + FLEN + 4;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef PS2_SHIFT_EN
      if (b == 8'h12 || b == 8'h59) begin
        m_shift = !m_brk; m_brk = 1'b0; m_ext = 1'b0;
        return;
      end
`endif
      if (!m_brk) begin
        a = m_ext ? 8'h00 : ref_ascii(b, m_shift);
        if (b != m_scan || a != m_ascii || !m_kp) push_exp(b, a, 1'b1, 1'b0, dl);
        m_scan = b; m_ascii = a; m_kp = 1'b1;
      end else begin
        if (b == m_scan) m_kp = 1'b0;
        push_exp(m_scan, m_ascii, m_kp, 1'b1, dl);
      end
      m_brk = 1'b0; m_ext = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch();
    case ($urandom_range(0, 3))
      0: begin #9.5 ps2_clk = 1'b0; #1 ps2_clk = 1'b1; @(negedge clk); end
      1: begin ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      glitch();
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && !bad_par && !bad_stop) model_byte(b);
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic do_reset();
    if (m_scan != 0 || m_ascii != 0 || m_kp) push_exp(8'h00, 8'h00, 1'b0, 1'b0, cyc + 3);
    m_scan = 0; m_ascii = 0; m_kp = 0; m_brk = 0; m_ext = 0; m_shift = 0;
    reset_n = 1'b0;
    wait_cyc(4);
    reset_n = 1'b1;
    zero_req++;
    wait_cyc(2);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, req);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT outputs move
  initial begin
    logic [7:0] ps, pa;
    logic pkp, pkr;
    exp_t e;
    wait (mon_en);
    @(negedge clk);
    ps = scan_code; pa = ascii_code; pkp = key_pressed; pkr = key_released;
    forever begin
      @(negedge clk);
      if (pkr) chk("key_released_width", {7'b0, key_released}, 8'h00);
      if (scan_code != ps || ascii_code != pa || key_pressed != pkp || key_released) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual scan=%02h ascii=%02h pressed=%0b released=%0b required=no change",
                   scan_code, ascii_code, key_pressed, key_released);
        end else begin
          e = exp_q.pop_front();
          chk("scan_code", scan_code, e.scan);
          chk("ascii_code", ascii_code, e.ascii);
          chk("key_pressed", {7'b0, key_pressed}, {7'b0, e.kp});
          chk("key_released", {7'b0, key_released}, {7'b0, e.kr});
          checks++;
          if (cyc > e.deadline) begin
            errors++;
            $display("FAIL latency actual=cycle %0d required<=cycle %0d", cyc, e.deadline);
          end
        end
      end
      ps = scan_code; pa = ascii_code; pkp = key_pressed; pkr = key_released;
      if (zero_done != zero_req) begin
        chk("reset_scan_code", scan_code, 8'h00);
        chk("reset_ascii_code", ascii_code, 8'h00);
        chk("reset_key_pressed", {7'b0, key_pressed}, 8'h00);
        chk("reset_key_released", {7'b0, key_released}, 8'h00);
        zero_done++;
      end
      if (end_done != end_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_outputs actual=%0d pending required=0", exp_q.size());
        end
        end_done++;
      end
    end
  end

  // stimulus: directed scenarios followed by randomized key traffic
  initial begin
    logic [7:0] k;
    reset_n = 1'b0;
    wait_cyc(5);
    reset_n = 1'b1;
    zero_req = 1;
    mon_en = 1'b1;
    wait_cyc(5);

    send(8'h1C);
    send(8'hF0); send(8'h1C);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    send(8'h32);
    send_frame(8'hA5, 1'b0, 1'b0, 5);
    wait_cyc(TMO + 200);
    send(8'h16);
    send(8'hE0); send(8'h75);
    send(8'h75);
    send_frame(8'h3C, 1'b0, 1'b0, 4);
    do_reset();
    send(8'h21);
`ifdef PS2_SHIFT_EN
    send(8'h12); send(8'h1C);
    send(8'h16);
    send(8'hF0); send(8'h12); send(8'h1C);
`endif

    for (int n = 0; n < 40; n++) begin
      k = POOL[$urandom_range(0, 13)];
      case ($urandom_range(0, 5))
        0, 1: send(k);
        2: begin send(8'hF0); send(k); end
        3: begin send(8'hE0); send(k); end
        4: begin send(8'hE0); send(8'hF0); send(k); end
        default: begin
          k = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 0) send_frame(k, 1'b1, 1'b0, 11);
          else send_frame(k, 1'b0, 1'b1, 11);
        end
      endcase
      if (n == 20) do_reset();
    end

    wait_cyc(50);
    end_req = 1;
    for (int w = 0; w < 20 && end_done != end_req; w++) wait_cyc(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
